instr_fetch: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of `decode`. It owns the architectural fetch PC and drives a single-outstanding-request handshake to instruction memory. It also holds the IF/ID pipeline register (`instr_id`, `pc_id`) and a one-entry skid buffer so that decode stalls never lose a returned word. Taken jumps and branches arrive from decode and are applied after the MIPS branch delay slot.

---
 rtl/instr_fetch.sv | 137 +++++++++++++
 tb/tb_instr_fetch.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the fetch PC, runs a single-outstanding
// request handshake to instruction memory, holds the IF/ID register and
// a one-entry skid buffer. Taken jumps/branches from decode are applied
// after the branch delay slot.
//
// state | meaning
// REQ   | request outstanding at fetch_pc; returned word goes to ID or buffer
// BUF   | returned word parked while decode stalls; no request issued
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_id,
  output logic [31:0] pc_id,
  output logic        instr_valid_id
);

  typedef enum logic {S_REQ, S_BUF} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] fetch_pc;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc;
  logic        pend;
  logic [31:0] pend_target;
  logic        id_ds;
  logic        ds_owed;

  logic        accept;
  logic        ack_req;
  logic        redir_take;
  logic        slot_captured;
  logic        load_id;

  // A jump in a delay slot (pending target, or ID holds the slot) is ignored.
  assign accept        = instr_valid_id & ~stall;
  assign ack_req       = (state == S_REQ) & imem_ack;
  assign redir_take    = accept & redirect & ~pend & ~id_ds;
  assign slot_captured = (state == S_BUF) | ack_req;
  assign load_id       = ~stall & slot_captured;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_REQ;
    else     state <= state_nxt;
  end

  // Next-state: park the word when decode stalls, drain once it releases
  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ:   if (imem_ack && stall) state_nxt = S_BUF;
      S_BUF:   if (!stall) state_nxt = S_REQ;
      default: state_nxt = S_REQ;
    endcase
  end

  // Request outputs decoded from state and fetch_pc only
  always_comb begin
    imem_req  = (state == S_REQ) & ~rst;
    imem_addr = fetch_pc;
  end

  // Fetch PC sequencing and deferred redirect target
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      pend        <= 1'b0;
      pend_target <= 32'h0;
    end else begin
      if (redir_take && slot_captured)
        fetch_pc <= redirect_target;
      else if (ack_req)
        fetch_pc <= pend ? pend_target : fetch_pc + 32'd4;

      if (redir_take && !slot_captured) begin
        pend        <= 1'b1;
        pend_target <= redirect_target;
      end else if (ack_req) begin
        pend <= 1'b0;
      end
    end
  end

  // Skid buffer captures a word returned while decode is stalled
  always_ff @(posedge clk) begin
    if (ack_req && stall) begin
      buf_instr <= imem_rdata;
      buf_pc    <= fetch_pc;
    end
  end

  // IF/ID register: load buffer or fresh word, else bubble, hold on stall
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_id       <= 32'h0;
      pc_id          <= 32'h0;
      instr_valid_id <= 1'b0;
    end else if (!stall) begin
      if (state == S_BUF) begin
        instr_id       <= buf_instr;
        pc_id          <= buf_pc;
        instr_valid_id <= 1'b1;
      end else if (imem_ack) begin
        instr_id       <= imem_rdata;
        pc_id          <= fetch_pc;
        instr_valid_id <= 1'b1;
      end else begin
        instr_id       <= 32'h0;
        instr_valid_id <= 1'b0;
      end
    end
  end

  // Mark the instruction following a taken redirect as its delay slot
  always_ff @(posedge clk) begin
    if (rst) begin
      id_ds   <= 1'b0;
      ds_owed <= 1'b0;
    end else if (load_id) begin
      id_ds   <= redir_take | ds_owed;
      ds_owed <= 1'b0;
    end else if (redir_take) begin
      ds_owed <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a program-order model.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        imem_ack = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr_id;
  logic [31:0] pc_id;
  logic        instr_valid_id;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  instr_fetch #(.RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .instr_id        (instr_id),
    .pc_id           (pc_id),
    .instr_valid_id  (instr_valid_id)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Program-order model: words are acked in fetch order, enter ID in the
  // same order; the word after a taken jump's delay slot is the target.
  bit          armed = 1'b0;
  int          fifo_cnt = 0;
  logic [31:0] f_addr, f_data;
  logic        m_valid = 1'b0;
  logic [31:0] m_instr = 32'h0;
  logic [31:0] m_pc = 32'h0;
  bit          have_last = 1'b0;
  logic [31:0] last_addr = 32'h0;
  bit          jmp_valid = 1'b0;
  logic [31:0] jmp_slot = 32'h0;
  logic [31:0] jmp_target = 32'h0;
  bit          ds_owed = 1'b0;
  bit          m_ds = 1'b0;
  logic        m_req;
  logic [31:0] m_a;

  function automatic logic [31:0] exp_fetch();
    if (!have_last) return RST_PC;
    if (jmp_valid && last_addr == jmp_slot) return jmp_target;
    return last_addr + 32'd4;
  endfunction

  always @(negedge clk) begin
    m_req = armed && !rst && fifo_cnt == 0;
    if (armed) begin
      chk("valid", {31'h0, instr_valid_id}, {31'h0, m_valid});
      chk("instr", instr_id, m_instr);
      chk("pc_id", pc_id, m_pc);
      chk("req", {31'h0, imem_req}, {31'h0, m_req});
      if (m_req) chk("addr", imem_addr, exp_fetch());
    end
    if (rst) begin
      armed = 1'b1; fifo_cnt = 0; m_valid = 1'b0; m_instr = 32'h0; m_pc = 32'h0;
      have_last = 1'b0; jmp_valid = 1'b0; ds_owed = 1'b0; m_ds = 1'b0;
    end else if (armed) begin
      if (m_valid && !stall && redirect && !m_ds) begin
        jmp_valid = 1'b1; jmp_slot = m_pc + 32'd4; jmp_target = redirect_target;
        ds_owed = 1'b1;
      end
      if (m_req && imem_ack) begin
        m_a = exp_fetch();
        if (jmp_valid && have_last && last_addr == jmp_slot) jmp_valid = 1'b0;
        last_addr = m_a; have_last = 1'b1;
        f_addr = m_a; f_data = mem_word(m_a); fifo_cnt = 1;
      end
      if (!stall) begin
        if (fifo_cnt != 0) begin
          m_instr = f_data; m_pc = f_addr; m_valid = 1'b1;
          m_ds = ds_owed; ds_owed = 1'b0; fifo_cnt = 0;
        end else begin
          m_instr = 32'h0; m_valid = 1'b0;
        end
      end
    end
  end

  task automatic cyc(input logic s, input logic rd, input logic [31:0] tgt,
                     input logic ak, input logic rs);
    @(posedge clk);
    #2;
    stall = s; redirect = rd; redirect_target = tgt; imem_ack = ak; rst = rs;
    #1;
  endtask

  logic [31:0] rnd;
  logic [31:0] tgt;
  logic        ak;

  initial begin
    // reset and zero-wait stream, stall during ack of 0x104
    cyc(0, 0, 0, 0, 1); chk("T reset req", {31'h0, imem_req}, 32'h0);
    cyc(0, 0, 0, 1, 0); chk("T first addr", imem_addr, 32'h100);
                        chk("T first req", {31'h0, imem_req}, 32'h1);
                        chk("T first valid", {31'h0, instr_valid_id}, 32'h0);
    cyc(1, 0, 0, 1, 0); chk("T pc 100", pc_id, 32'h100);
                        chk("T instr 100", instr_id, 32'h1257_6520);
                        chk("T addr 104", imem_addr, 32'h104);
    cyc(1, 0, 0, 1, 0); chk("T buf req", {31'h0, imem_req}, 32'h0);
                        chk("T buf instr", instr_id, 32'h1257_6520);
    cyc(1, 0, 0, 0, 0); chk("T buf pc", pc_id, 32'h100);
    cyc(0, 0, 0, 1, 0); chk("T buf req2", {31'h0, imem_req}, 32'h0);
    cyc(0, 0, 0, 1, 0); chk("T drain pc", pc_id, 32'h104);
                        chk("T drain instr", instr_id, 32'h1253_6524);
                        chk("T drain addr", imem_addr, 32'h108);
    // redirect with zero-wait memory
    cyc(0, 1, 32'h200, 1, 0); chk("T pc 108", pc_id, 32'h108);
    cyc(0, 0, 0, 1, 0);       chk("T ds 10c", pc_id, 32'h10C);
                              chk("T addr 200", imem_addr, 32'h200);
    cyc(0, 1, 32'h400, 1, 0); chk("T pc 200", pc_id, 32'h200);
    cyc(0, 0, 0, 1, 0);       chk("T ds 204", pc_id, 32'h204);
                              chk("T addr 400", imem_addr, 32'h400);
    cyc(0, 0, 0, 1, 0);       chk("T pc 400", pc_id, 32'h400);
    cyc(0, 1, 32'h200, 1, 0); chk("T pc 404", pc_id, 32'h404);
    // redirect with 2-wait memory
    cyc(0, 0, 0, 0, 0);       chk("T w ds 408", pc_id, 32'h408);
    cyc(0, 0, 0, 0, 0);       chk("T w bubble", {31'h0, instr_valid_id}, 32'h0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 32'h400, 0, 0); chk("T w pc 200", pc_id, 32'h200);
    cyc(0, 0, 0, 0, 0);       chk("T w pend bubble", {31'h0, instr_valid_id}, 32'h0);
                              chk("T w addr 204", imem_addr, 32'h204);
    cyc(0, 0, 0, 1, 0);       chk("T w addr 204b", imem_addr, 32'h204);
    cyc(0, 0, 0, 0, 0);       chk("T w ds 204", pc_id, 32'h204);
                              chk("T w addr 400", imem_addr, 32'h400);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    // stalled jump held for 4 stall cycles plus accept, redirect in slot
    cyc(1, 1, 32'h800, 1, 0); chk("T w pc 400", pc_id, 32'h400);
    cyc(1, 1, 32'h800, 1, 0); chk("T sj req", {31'h0, imem_req}, 32'h0);
    cyc(1, 1, 32'h800, 1, 0);
    cyc(1, 1, 32'h800, 1, 0);
    cyc(0, 1, 32'h800, 1, 0); chk("T sj hold pc", pc_id, 32'h400);
    cyc(0, 1, 32'hC00, 1, 0); chk("T sj ds", pc_id, 32'h404);
                              chk("T sj addr 800", imem_addr, 32'h800);
    cyc(0, 0, 0, 1, 0);       chk("T sj pc 800", pc_id, 32'h800);
                              chk("T sj addr 804", imem_addr, 32'h804);
    // address wrap, then reset during an outstanding request
    cyc(0, 1, 32'hFFFF_FFF8, 1, 0);
    cyc(0, 0, 0, 1, 0);       chk("T wrap ds", pc_id, 32'h808);
    cyc(0, 0, 0, 1, 0);       chk("T wrap pc", pc_id, 32'hFFFF_FFF8);
    cyc(0, 0, 0, 0, 0);       chk("T wrap last", pc_id, 32'hFFFF_FFFC);
                              chk("T wrap addr", imem_addr, 32'h0);
    cyc(0, 0, 0, 1, 1);       chk("T rst req", {31'h0, imem_req}, 32'h0);
    cyc(0, 0, 0, 0, 0);       chk("T rst valid", {31'h0, instr_valid_id}, 32'h0);
                              chk("T rst pc", pc_id, 32'h0);
                              chk("T rst addr", imem_addr, 32'h100);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rnd = $urandom;
      if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF0 + {28'h0, rnd[1:0], 2'b00};
      else                           tgt = {rnd[31:2], 2'b00};
      case ((i / 500) % 3)
        0:       ak = 1'b1;
        1:       ak = ($urandom_range(0, 1) == 0);
        default: ak = ($urandom_range(0, 3) == 0);
      endcase
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, tgt, ak,
          $urandom_range(0, 299) == 0);
    end
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
